// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit that owns the MIPS HI/LO register pair.
// A shift-add multiplier and a restoring divider share the same product/remainder registers.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  op_r;
  logic [31:0] abs_a_r;
  logic [31:0] abs_b_r;
  logic        neg_res_r;
  logic        neg_rem_r;
  logic        dz_r;
  logic [4:0]  cnt_r;
  logic [31:0] acc_r;
  logic [31:0] low_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;

  logic        signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic        zero_div_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_sh_s;
  logic        div_ge_s;
  logic [31:0] div_diff_s;
  logic [31:0] acc_step_s;
  logic [31:0] low_step_s;
  logic [63:0] prod_s;
  logic [63:0] prod_neg_s;
  logic [31:0] quo_neg_s;
  logic [31:0] rem_neg_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  // Operand magnitudes and sign bookkeeping for an incoming operation
  assign signed_s   = ~op[0];
  assign a_neg_s    = signed_s & src_a[31];
  assign b_neg_s    = signed_s & src_b[31];
  assign abs_a_s    = a_neg_s ? (32'd0 - src_a) : src_a;
  assign abs_b_s    = b_neg_s ? (32'd0 - src_b) : src_b;
  assign zero_div_s = op[1] & (src_b == 32'd0);

  // One multiply step adds the multiplicand with carry; one divide step trial-subtracts
  assign mul_sum_s  = {1'b0, acc_r} + (low_r[0] ? {1'b0, abs_a_r} : 33'd0);
  assign div_sh_s   = {acc_r, low_r[31]};
  assign div_ge_s   = (div_sh_s >= {1'b0, abs_b_r});
  assign div_diff_s = div_sh_s[31:0] - abs_b_r;

  assign prod_s     = {acc_r, low_r};
  assign prod_neg_s = 64'd0 - prod_s;
  assign quo_neg_s  = 32'd0 - low_r;
  assign rem_neg_s  = 32'd0 - acc_r;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (zero_div_s) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 5'd31) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Iteration step for the shared product / remainder-quotient registers
  always_comb begin
    acc_step_s = acc_r;
    low_step_s = low_r;
    if (op_r[1]) begin
      if (div_ge_s) begin
        acc_step_s = div_diff_s;
        low_step_s = {low_r[30:0], 1'b1};
      end else begin
        acc_step_s = div_sh_s[31:0];
        low_step_s = {low_r[30:0], 1'b0};
      end
    end else begin
      acc_step_s = mul_sum_s[32:1];
      low_step_s = {mul_sum_s[0], low_r[31:1]};
    end
  end

  // Sign correction; magnitude divide already gives 0x80000000 for -2^31 / -1
  always_comb begin
    fix_hi_s = prod_s[63:32];
    fix_lo_s = prod_s[31:0];
    case (op_r)
      OP_MULT: begin
        if (neg_res_r) begin
          fix_hi_s = prod_neg_s[63:32];
          fix_lo_s = prod_neg_s[31:0];
        end else begin
          fix_hi_s = prod_s[63:32];
          fix_lo_s = prod_s[31:0];
        end
      end
      OP_MULTU: begin
        fix_hi_s = prod_s[63:32];
        fix_lo_s = prod_s[31:0];
      end
      OP_DIV: begin
        fix_lo_s = neg_res_r ? quo_neg_s : low_r;
        fix_hi_s = neg_rem_r ? rem_neg_s : acc_r;
      end
      OP_DIVU: begin
        fix_lo_s = low_r;
        fix_hi_s = acc_r;
      end
      default: begin
        fix_hi_s = prod_s[63:32];
        fix_lo_s = prod_s[31:0];
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, HI/LO ownership and status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_r       <= 2'd0;
      abs_a_r    <= 32'd0;
      abs_b_r    <= 32'd0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      dz_r       <= 1'b0;
      cnt_r      <= 5'd0;
      acc_r      <= 32'd0;
      low_r      <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r       <= op;
            cnt_r      <= 5'd0;
            busy_r     <= 1'b1;
            div_zero_r <= 1'b0;
            if (zero_div_s) begin
              // Preload so the common divide write-back yields hi=src_a, lo=all ones
              dz_r      <= 1'b1;
              neg_res_r <= 1'b0;
              neg_rem_r <= 1'b0;
              acc_r     <= src_a;
              low_r     <= 32'hFFFF_FFFF;
            end else begin
              dz_r      <= 1'b0;
              abs_a_r   <= abs_a_s;
              abs_b_r   <= abs_b_s;
              neg_res_r <= a_neg_s ^ b_neg_s;
              neg_rem_r <= a_neg_s;
              acc_r     <= 32'd0;
              low_r     <= op[1] ? abs_a_s : abs_b_s;
            end
          end else begin
            if (hi_we) begin
              hi_r <= wdata;
            end
            if (lo_we) begin
              lo_r <= wdata;
            end
          end
        end
        CALC: begin
          acc_r <= acc_step_s;
          low_r <= low_step_s;
          cnt_r <= cnt_r + 5'd1;
        end
        FIX: begin
          hi_r       <= fix_hi_s;
          lo_r       <= fix_lo_s;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          div_zero_r <= dz_r;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit with hand-written multi-cycle sequences.
module tb_muldiv_unit;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_cyc;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int ec);
    vecs[i].name = nm; vecs[i].op = o; vecs[i].a = a; vecs[i].b = b;
    vecs[i].exp_hi = eh; vecs[i].exp_lo = el; vecs[i].exp_dz = ed; vecs[i].exp_cyc = ec;
  endtask

  // Entered and left at a negedge; counts edges from acceptance to the done pulse.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic hw, input logic lw, input logic [31:0] wd, input bit inject,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed, input int ec);
    int n;
    bit got;
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi_we = hw; lo_we = lw; wdata = wd;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk({nm, " busy_after_start"}, {63'd0, busy}, 64'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      if (inject && n == 5) begin
        start = 1'b1; op = DIVU; src_a = 32'd0; src_b = 32'd0;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      @(posedge CLK);
      n++;
      @(negedge CLK);
      start = 1'b0; hi_we = 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL %s done_timeout: got no done expected done within 100 cycles", nm);
    end
    done_cyc = cyc;
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    chk({nm, " div_zero"}, {63'd0, div_zero}, {63'd0, ed});
    chk({nm, " latency"}, 64'(n), 64'(ec));
    chk({nm, " busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int t1;
    set_vec(0,  "multu_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    set_vec(1,  "mult_m3x7",   MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    set_vec(2,  "mult_min2",   MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
    set_vec(3,  "mult_5xm4",   MULT,  32'd5,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0, 33);
    set_vec(4,  "div_m7d2",    DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    set_vec(5,  "div_7dm2",    DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33);
    set_vec(6,  "divu_100d7",  DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33);
    set_vec(7,  "div_min_m1",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
    set_vec(8,  "divu_max_d1", DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33);
    set_vec(9,  "divu_5d0",    DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1);
    set_vec(10, "multu_2x3",   MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 33);
    set_vec(11, "div_m8d0",    DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1);

    RST = 1'b1; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (2) @(negedge CLK);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset div_zero", {63'd0, div_zero}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge CLK);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both hi", {32'd0, hi}, 64'h0000_0000_AAAA_5555);
    chk("mt_both lo", {32'd0, lo}, 64'h0000_0000_AAAA_5555);

    // Asynchronous reset ten edges into CALC
    start = 1'b1; op = MULTU; src_a = 32'd7; src_b = 32'd9;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midcalc_rst busy", {63'd0, busy}, 64'd0);
    chk("midcalc_rst done", {63'd0, done}, 64'd0);
    chk("midcalc_rst hi", {32'd0, hi}, 64'd0);
    chk("midcalc_rst lo", {32'd0, lo}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 32'd0, 1'b0,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, vecs[i].exp_cyc);
    end

    // start + MTHI during CALC must be ignored
    run_op("busy_inject", MULTU, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 1'b1,
           32'd0, 32'd12, 1'b0, 33);
    @(negedge CLK);
    chk("after_inject busy", {63'd0, busy}, 64'd0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge CLK);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_1234 hi", {32'd0, hi}, 64'h0000_0000_0000_1234);
    chk("mt_1234 lo", {32'd0, lo}, 64'h0000_0000_0000_1234);

    // start and MTLO in the same IDLE cycle: write dropped
    run_op("start_vs_mtlo", MULTU, 32'd2, 32'd2, 1'b0, 1'b1, 32'h0000_5555, 1'b0,
           32'd0, 32'd4, 1'b0, 33);

    // Back-to-back: next start issued during the done cycle
    run_op("b2b_first", MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd42, 1'b0, 33);
    t1 = done_cyc;
    run_op("b2b_second", DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2, 32'd14, 1'b0, 33);
    chk("b2b done_spacing", 64'(done_cyc - t1), 64'd34);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS core. The execute stage issues MULT/MULTU/DIV/DIVU operands with a start pulse, stalls on `busy`, and reads results from `hi`/`lo`. MTHI/MTLO writes are also accepted here. This replaces single-cycle `*`, `/` and `%` with a 32-step shift-add / restoring-divide datapath.

## Interface
- No parameters; datapath width fixed at 32.
- `CLK` in 1: clock, all state updates on rising edge.
- `RST` in 1: asynchronous reset, active-high.
- `start` in 1: issue operation; sampled only in IDLE.
- `op` in 2: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `src_a` in 32: rs operand (multiplicand / dividend).
- `src_b` in 32: rt operand (multiplier / divisor).
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: operation in progress; EX must stall MFHI/MFLO/new ops.
- `done` out 1: one-cycle pulse when `hi`/`lo` updated by an operation.
- `div_zero` out 1: registered flag, set with `done` when the last divide had divisor 0; cleared on next accepted start.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start`: latch `op`; compute `|a|`, `|b|` for signed ops (unsigned ops use raw values); record result signs; clear step counter; go to CALC, `busy`=1.
- IDLE + `start` + DIV/DIVU with `src_b`==0: go directly to FIX with `lo`=32'hFFFFFFFF, `hi`=`src_a`, `div_zero`=1.
- CALC, multiply: 64-bit product register {P_hi, P_lo}, P_lo initialised to `|b|`. Each step: if P_lo[0], add `|a|` to P_hi with carry-out; shift right 1 through carry. 32 steps.
- CALC, divide: restoring. Remainder R (33 bits), quotient Q initialised to `|a|`. Each step: shift {R,Q} left 1; if R ≥ `|b|`, R -= `|b|` and set Q[0]=1. 32 steps.
- After step 32 (counter 31 → wrap), go to FIX.
- FIX: signed MULT with negative sign → 64-bit two's-complement negate. Signed DIV: quotient negated if sign(a)≠sign(b); remainder takes sign of dividend. Write `hi`/`lo` (mult: {hi,lo}=product; div: lo=quotient, hi=remainder). Pulse `done`; go to IDLE, `busy`=0.
- −2^31 / −1 (DIV): lo=32'h80000000, hi=0, no flag.
- MTHI/MTLO: in IDLE with no `start`, `hi_we`/`lo_we` load `wdata` into the register; both may be asserted together. Ignored while `busy`. `start` with a write in the same cycle: start wins, write dropped.
- `start` while busy: ignored, no queuing.
- `hi`/`lo` retain old values throughout CALC; they change only in FIX or on MT writes.

## Timing
- Reset (async, any state): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter=0; an in-flight operation is discarded.
- Start accepted at edge k: `busy` high after edge k. CALC occupies edges k+1..k+32. FIX at edge k+33: `hi`/`lo` valid, `done`=1 and `busy`=0 after edge k+33; `done` drops after edge k+34.
- Divide-by-zero: FIX at edge k+1; results and `done` after edge k+1 (2-cycle turnaround).
- Back-to-back: a new `start` is accepted at the edge following `done` assertion (state is IDLE during the `done` cycle).
- MT write at edge k: register value visible after edge k.

## Test plan
- Reset mid-CALC (edge k+10): `busy`, `done`, `hi`, `lo` → 0 immediately. Then MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, `done` 33 cycles after start.
- MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 5/0 → after 2 cycles: lo=0xFFFFFFFF, hi=5, `div_zero`=1. Next MULTU 2×3 clears `div_zero` and gives lo=6.
- `start` pulsed at CALC cycle 5 plus `hi_we`: no effect. After completion, `hi_we`+`lo_we` with wdata=0x1234 → both 0x1234.
- Same-cycle `start` (MULTU 2×2) and `lo_we` in IDLE: lo=4 at finish, write dropped. Back-to-back starts give `done` exactly 34 cycles apart.
